// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, function-code and state definitions for the ALU sequencing controller.
package alu_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] FN_ADD  = 3'd0;
  localparam logic [2:0] FN_SLL  = 3'd1;
  localparam logic [2:0] FN_SLT  = 3'd2;
  localparam logic [2:0] FN_SLTU = 3'd3;
  localparam logic [2:0] FN_XOR  = 3'd4;
  localparam logic [2:0] FN_SR   = 3'd5;
  localparam logic [2:0] FN_OR   = 3'd6;
  localparam logic [2:0] FN_AND  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic logic is_shift_fn(input logic [2:0] fn);
    return (fn == FN_SLL) || (fn == FN_SR);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into ALU function, control bit and operands.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output logic [2:0]  func,
  output logic        control,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        illegal
);

  logic [31:0] src_b;

  always_comb begin
    func    = FN_ADD;
    control = 1'b0;
    op_a    = '0;
    op_b    = '0;
    illegal = 1'b0;
    src_b   = (opcode == OPC_OP) ? rs2 : imm;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        func = funct3;
        op_a = rs1;
        op_b = src_b;
        if (funct3 == FN_SR) control = funct7b5;
        // SUB is done as an add of the negated operand, so the ALU never sees control=1 for it
        if (is_shift_fn(funct3)) op_b = {27'b0, src_b[4:0]};
        else if (opcode == OPC_OP && funct3 == FN_ADD && funct7b5) op_b = ~rs2 + 32'd1;
      end
      OPC_LUI: begin
        op_a    = imm;
        control = 1'b1;
      end
      OPC_AUIPC: begin
        op_a = pc;
        op_b = imm;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Issue/execute/hold sequencer around an external combinational ALU.
// Optional ALU_SERIAL_SHIFT_EN: shifts run one bit per cycle in the SHIFT state.
//
// state | meaning
// IDLE  | waiting for an issue request
// EXEC  | single-cycle ALU operation on registered operands
// SHIFT | serial shift, one bit position per cycle (ALU_SERIAL_SHIFT_EN only)
// HOLD  | result presented until out_ready
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rd,
  output logic [2:0]  alu_func,
  output logic        alu_control,
  output logic [31:0] alu_in_A,
  output logic [31:0] alu_in_B,
  input  logic [31:0] alu_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  state_t      state;
  logic [2:0]  func_q;
  logic        ctrl_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  rd_q;
  logic [4:0]  cnt_q;
  logic        illegal_q;

  logic [2:0]  dec_func;
  logic        dec_control;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_illegal;
  logic        accept;
  logic        start_serial;
  logic        busy;

  alu_op_decode u_decode (
    .opcode   (in_opcode),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .imm      (in_imm),
    .pc       (in_pc),
    .func     (dec_func),
    .control  (dec_control),
    .op_a     (dec_a),
    .op_b     (dec_b),
    .illegal  (dec_illegal)
  );

  assign in_ready = (state == IDLE) || (state == HOLD && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_SERIAL_SHIFT_EN
  // Zero shift amount falls through to a normal EXEC cycle with B=0
  assign start_serial = is_shift_fn(dec_func) && (dec_b[4:0] != 5'd0);
`else
  assign start_serial = 1'b0;
`endif

  assign busy        = (state == EXEC) || (state == SHIFT);
  assign alu_func    = busy ? func_q : 3'd0;
  assign alu_control = busy ? ctrl_q : 1'b0;
  assign alu_in_A    = busy ? a_q : 32'd0;
  assign alu_in_B    = (state == EXEC) ? b_q : (state == SHIFT) ? 32'd1 : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      func_q      <= '0;
      ctrl_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      func_q    <= dec_func;
      ctrl_q    <= dec_control;
      a_q       <= dec_a;
      b_q       <= dec_b;
      rd_q      <= in_rd;
      cnt_q     <= dec_b[4:0];
      illegal_q <= dec_illegal;
      out_valid <= 1'b0;
      state     <= start_serial ? SHIFT : EXEC;
    end else begin
      case (state)
        EXEC: begin
          out_result  <= illegal_q ? 32'd0 : alu_out;
          out_illegal <= illegal_q;
          out_rd      <= rd_q;
          out_valid   <= 1'b1;
          state       <= HOLD;
        end
        SHIFT: begin
          a_q   <= alu_out;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            out_result  <= alu_out;
            out_illegal <= 1'b0;
            out_rd      <= rd_q;
            out_valid   <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
